dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port: the target side of the core's data-memory requests. It is a valid/ready handshaked, multi-cycle-latency word memory with byte enables, replacing the zero-latency combinational memory stage when the core moves to a handshaked memory interface. It accepts one request at a time, waits a fixed latency, performs the access, then holds a response until the core consumes it.

---
 rtl/dmem_if.sv | 40 ++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request/response bundle between the core
// load/store unit (master) and a data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_be,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked, fixed-latency word memory with byte enables.
// Define DMEM_STATS_EN to add saturating load/store/error counters.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;

  logic [31:0]   rdata_q;
  logic          err_q;

  // Cells hold data XOR word index, so power-on-zero storage
  // reads back as word i = i without any reset of the array.
  logic [31:0]   store [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [31:0]   idx_word;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic          acc;
  logic          err;

  assign idx      = a_addr[IW+1:2];
  assign idx_word = 32'(idx);
  assign cur      = store[idx] ^ idx_word;

  assign acc = (state == WAIT) && (cnt == '0);
  assign err = (a_addr[1:0] != 2'b00)
            || ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    merged = cur;
    for (int b = 0; b < 4; b++) begin
      if (a_be[b]) merged[8*b +: 8] = a_wdata[8*b +: 8];
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_we    <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_be    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_we    <= bus.req_we;
            a_addr  <= bus.req_addr;
            a_wdata <= bus.req_wdata;
            a_be    <= bus.req_be;
            cnt     <= CW'(LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            err_q   <= err;
            rdata_q <= (a_we || err) ? 32'h0 : cur;
            state   <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst so a reset landing on the access edge drops the store.
  always_ff @(posedge clk) begin
    if (rst && acc && a_we && !err) begin
      store[idx] <= merged ^ idx_word;
    end
  end

`ifdef DMEM_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (acc) begin
      unique case (1'b1)
        err:     stat_errs   <= sat_inc(stat_errs);
        a_we:    stat_stores <= sat_inc(stat_stores);
        default: stat_loads  <= sat_inc(stat_loads);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, corner sequences and random
// traffic checked against an array model of the word memory.
module tb_dmem_responder;
  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if bus();

`ifdef DMEM_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DMEM_STATS_EN
    ,
    .stat_loads(stat_loads),
    .stat_stores(stat_stores),
    .stat_errs(stat_errs)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic we,
                             input logic [31:0] addr,
                             input logic [31:0] wd,
                             input logic [3:0] be,
                             output logic [31:0] rd,
                             output logic er);
    int w;
    logic [31:0] mask;
    er = (addr % 4 != 0) || ((addr >> 2) >= 32'(DEPTH));
    rd = 32'h0;
    if (!er) begin
      w = int'(addr >> 2);
      if (!we) begin
        rd = model[w];
      end else begin
        mask = 32'h0;
        for (int b = 0; b < 4; b++)
          if (be[b]) mask = mask | (32'hFF << (8 * b));
        model[w] = (model[w] & ~mask) | (wd & mask);
      end
    end
  endtask

  task automatic xact(input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [3:0] be,
                      input int hold,
                      output logic [31:0] rd,
                      output logic er);
    int n;
    int lat;
    rd = 32'h0;
    er = 1'b0;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 32'h0000_0024;
    bus.req_wdata = 32'h5A5A_5A5A;
    bus.req_be    = 4'hF;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(LAT + 1));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, rd);
      chk("hold_rsp_err", 32'(bus.rsp_err), 32'(er));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_one(input string name,
                         input logic we,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [3:0] be,
                         input int hold);
    logic [31:0] erd;
    logic [31:0] rd;
    logic eer;
    logic er;
    model_apply(we, addr, wd, be, erd, eer);
    xact(we, addr, wd, be, hold, rd, er);
    chk({name, "_rdata"}, rd, erd);
    chk({name, "_err"}, 32'(er), 32'(eer));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({name, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({name, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
`ifdef DMEM_STATS_EN
    chk({name, "_stat_loads"}, 32'(stat_loads), 32'd0);
    chk({name, "_stat_stores"}, 32'(stat_stores), 32'd0);
    chk({name, "_stat_errs"}, 32'(stat_errs), 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [31:0] a;
    logic we;
    int r;

    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);

    vecs[0]  = '{1'b0, 32'h014, 32'h0, 4'hF, 32'h0000_0005, 1'b0};
    vecs[1]  = '{1'b1, 32'h008, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h008, 32'h0, 4'hF, 32'h0000_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 32'h006, 32'h0, 4'hF, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 32'h200, 32'h0, 4'hF, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 32'h200, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h00C, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h00C, 32'h0, 4'hF, 32'h0000_0003, 1'b0};
    vecs[8]  = '{1'b0, 32'h1FC, 32'h0, 4'hF, 32'h0000_007F, 1'b0};
    vecs[9]  = '{1'b1, 32'h1FC, 32'hCAFE_F00D, 4'b1100, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h1FC, 32'h0, 4'hF, 32'hCAFE_007F, 1'b0};

    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    foreach (vecs[i]) begin
      model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er);
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
           (i == 2) ? 3 : 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
    end

    // Reset lands on the edges where the pending store would access.
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h1234_5678;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("midwait_reset");
    rst = 1'b1;

    run_one("after_reset_load10", 1'b0, 32'h10, 32'h0, 4'hF, 0);
    run_one("stat_load", 1'b0, 32'h4, 32'h0, 4'hF, 1);
    run_one("stat_store", 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 0);
    run_one("stat_misaligned", 1'b0, 32'h6, 32'h0, 4'hF, 2);
`ifdef DMEM_STATS_EN
    chk("stat_loads", 32'(stat_loads), 32'd2);
    chk("stat_stores", 32'(stat_stores), 32'd1);
    chk("stat_errs", 32'(stat_errs), 32'd1);
`endif

    for (int t = 0; t < 60; t++) begin
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      if (r == 0)
        a = (32'($urandom_range(0, DEPTH - 1)) << 2)
          | 32'($urandom_range(1, 3));
      else if (r == 1)
        a = 32'(DEPTH + int'($urandom_range(0, 300))) << 2;
      else
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      run_one($sformatf("rand%0d", t), we, a, $urandom,
              4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    for (int w = 0; w < DEPTH; w++)
      run_one($sformatf("sweep%0d", w), 1'b0, 32'(w) << 2, 32'h0, 4'hF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
